fc_rx_word_sync: RTL and testbench

- Parametrised receive word synchroniser for the FC transceiver wrappers.
- Sits between the PHY's little-endian parallel RX output and the big-endian Avalon-ST RX stream.
- Locates K28.5 (0xBC, k=1) in any byte lane and runs an acquire/sync/loss state machine with error hysteresis.
- Emits lane-realigned, byte-swapped words and keeps saturating error and loss-of-sync counters.

---
 rtl/fc_rx_word_sync.sv | 235 +++++++++++++++++++++++
 tb/tb_fc_rx_word_sync.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_rx_word_sync.sv
// fc_rx_word_sync
//   Receive word synchroniser between the PHY's little-endian parallel RX
//   output and a big-endian Avalon-ST RX stream. Finds K28.5 (0xBC, k=1) in
//   any byte lane, runs a LOS/ACQ/SYNC state machine with error hysteresis,
//   realigns words to the K28.5 lane and byte-swaps them to big-endian.
//   Saturating counters track invalid words and SYNC->LOS transitions.
//
// Ports
//   clk            single clock
//   reset          synchronous, active-high
//   in_valid       input word qualifier
//   in_data        PHY data, little-endian (lane 0 = bits [7:0] = first byte)
//   in_datak       per-lane K flags
//   in_errdetect   per-lane code-group error
//   in_disperr     per-lane disparity error
//   cnt_clear      synchronous clear of both statistics counters
//   out_valid      out_data/out_datak valid and block in SYNC
//   out_data       aligned word, big-endian (MSB byte = first byte)
//   out_datak      K flags, big-endian order
//   aligned        high while in SYNC
//   sync_state     0 = LOS, 1 = ACQ, 2 = SYNC
//   offset         latched K28.5 lane
//   code_err_cnt   saturating count of invalid words
//   sync_loss_cnt  saturating count of SYNC->LOS transitions
module fc_rx_word_sync #(
  parameter int BYTES        = 4,
  parameter int ACQUIRE_CNT  = 3,
  parameter int LOSS_ERR_CNT = 4,
  parameter int CNT_W        = 16,
  localparam int W           = 8 * BYTES,
  localparam int OFF_W       = ($clog2(BYTES) > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [BYTES-1:0] in_datak,
  input  logic [BYTES-1:0] in_errdetect,
  input  logic [BYTES-1:0] in_disperr,
  input  logic             cnt_clear,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [BYTES-1:0] out_datak,
  output logic             aligned,
  output logic [1:0]       sync_state,
  output logic [OFF_W-1:0] offset,
  output logic [CNT_W-1:0] code_err_cnt,
  output logic [CNT_W-1:0] sync_loss_cnt
);

  localparam int CTR_W = 4;

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [OFF_W-1:0]   offset_q, off_nxt;
  logic [CTR_W-1:0]   acq_q, acq_nxt;
  logic [CTR_W-1:0]   credit_q, credit_nxt;
  logic               run_q, run_nxt;
  logic               loss_evt;

  logic [BYTES-1:0]   k_lane;
  logic [BYTES-1:0]   off_onehot;
  logic [OFF_W-1:0]   kpos;
  logic               k_found;
  logic               bad_word;
  logic               stray_k;

  logic [W-1:0]       prev_data_p0;
  logic [BYTES-1:0]   prev_k_p0;

  logic [2*W-1:0]     pair_data;
  logic [2*BYTES-1:0] pair_k;
  logic [W-1:0]       al_data;
  logic [BYTES-1:0]   al_k;
  logic [W-1:0]       be_data;
  logic [BYTES-1:0]   be_k;

  logic               out_valid_p1;
  logic [W-1:0]       out_data_p1;
  logic [BYTES-1:0]   out_datak_p1;
  logic               aligned_p1;
  logic [CNT_W-1:0]   code_err_q;
  logic [CNT_W-1:0]   sync_loss_q;

  // K28.5 detection per lane, and big-endian swap of the aligned word
  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    assign k_lane[g] = in_datak[g] & (in_data[8*g +: 8] == 8'hBC);
    assign be_data[8*(BYTES-1-g) +: 8] = al_data[8*g +: 8];
    assign be_k[BYTES-1-g]             = al_k[g];
  end

  always_comb begin
    k_found = 1'b0;
    kpos    = '0;
    // Descending scan so the lowest K-lane index wins
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (k_lane[i]) begin
        k_found = 1'b1;
        kpos    = OFF_W'(i);
      end
    end
  end

  assign bad_word   = (|in_errdetect) | (|in_disperr);
  assign off_onehot = BYTES'(1) << offset_q;
  assign stray_k    = |(k_lane & ~off_onehot);

  always_comb begin
    state_nxt  = state_q;
    off_nxt    = offset_q;
    acq_nxt    = acq_q;
    credit_nxt = credit_q;
    run_nxt    = run_q;
    loss_evt   = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_LOS: begin
          if (!bad_word && k_found) begin
            off_nxt    = kpos;
            acq_nxt    = CTR_W'(1);
            credit_nxt = '0;
            run_nxt    = 1'b0;
            state_nxt  = (ACQUIRE_CNT == 1) ? ST_SYNC : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (bad_word) begin
            state_nxt = ST_LOS;
            acq_nxt   = '0;
          end else if (k_found) begin
            if (kpos == offset_q) begin
              acq_nxt = acq_q + CTR_W'(1);
              if ((acq_q + CTR_W'(1)) >= CTR_W'(ACQUIRE_CNT)) begin
                state_nxt  = ST_SYNC;
                credit_nxt = '0;
                run_nxt    = 1'b0;
              end
            end else begin
              off_nxt = kpos;
              acq_nxt = CTR_W'(1);
            end
          end
        end
        ST_SYNC: begin
          // An invalid word with a stray K28.5 is still one bad word
          if (bad_word || stray_k) begin
            run_nxt = 1'b0;
            if ((credit_q + CTR_W'(1)) >= CTR_W'(LOSS_ERR_CNT)) begin
              state_nxt  = ST_LOS;
              credit_nxt = '0;
              acq_nxt    = '0;
              loss_evt   = 1'b1;
            end else begin
              credit_nxt = credit_q + CTR_W'(1);
            end
          end else if (run_q) begin
            // Second good word of a run pays back one credit
            run_nxt = 1'b0;
            if (credit_q != '0) credit_nxt = credit_q - CTR_W'(1);
          end else begin
            run_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_LOS;
      endcase
    end
  end

  // Realignment: lanes offset..BYTES-1 of the previous word followed by
  // lanes 0..offset-1 of the current word. The updated offset is used so a
  // word that enters SYNC is already aligned to the lane it latched.
  assign pair_data = {in_data, prev_data_p0} >> {off_nxt, 3'b000};
  assign pair_k    = {in_datak, prev_k_p0} >> off_nxt;
  assign al_data   = pair_data[W-1:0];
  assign al_k      = pair_k[BYTES-1:0];

  // Stage p0: control state and previous-word register
  // Stage p1: big-endian output register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOS;
      offset_q     <= '0;
      acq_q        <= '0;
      credit_q     <= '0;
      run_q        <= 1'b0;
      prev_data_p0 <= '0;
      prev_k_p0    <= '0;
      out_valid_p1 <= 1'b0;
      out_data_p1  <= '0;
      out_datak_p1 <= '0;
      aligned_p1   <= 1'b0;
      code_err_q   <= '0;
      sync_loss_q  <= '0;
    end else begin
      out_valid_p1 <= in_valid && (state_nxt == ST_SYNC);
      if (in_valid) begin
        state_q      <= state_nxt;
        offset_q     <= off_nxt;
        acq_q        <= acq_nxt;
        credit_q     <= credit_nxt;
        run_q        <= run_nxt;
        prev_data_p0 <= in_data;
        prev_k_p0    <= in_datak;
        out_data_p1  <= be_data;
        out_datak_p1 <= be_k;
        aligned_p1   <= (state_nxt == ST_SYNC);
      end
      if (cnt_clear) begin
        code_err_q <= '0;
      end else if (in_valid && bad_word && !(&code_err_q)) begin
        code_err_q <= code_err_q + CNT_W'(1);
      end
      if (cnt_clear) begin
        sync_loss_q <= '0;
      end else if (loss_evt && !(&sync_loss_q)) begin
        sync_loss_q <= sync_loss_q + CNT_W'(1);
      end
    end
  end

  assign out_valid     = out_valid_p1;
  assign out_data      = out_data_p1;
  assign out_datak     = out_datak_p1;
  assign aligned       = aligned_p1;
  assign sync_state    = state_q;
  assign offset        = offset_q;
  assign code_err_cnt  = code_err_q;
  assign sync_loss_cnt = sync_loss_q;

endmodule

// File: tb/tb_fc_rx_word_sync.sv
// Directed bench for fc_rx_word_sync (BYTES=4). A second instance with
// CNT_W=4 shares the same inputs to exercise counter saturation.
module tb_fc_rx_word_sync;

  localparam logic [31:0] IDLE0   = 32'hB5B595BC;  // K28.5 in lane 0
  localparam logic [3:0]  IDLE0_K = 4'b0001;
  localparam logic [31:0] ROT2    = 32'h95BCB5B5;  // K28.5 in lane 2
  localparam logic [3:0]  ROT2_K  = 4'b0100;
  localparam logic [31:0] STRAY   = 32'h95BC95BC;  // K28.5 in lanes 0 and 2
  localparam logic [3:0]  STRAY_K = 4'b0101;
  localparam logic [31:0] BE_IDLE = 32'hBC95B5B5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_datak = '0;
  logic [3:0]  in_errdetect = '0;
  logic [3:0]  in_disperr = '0;
  logic        cnt_clear = 1'b0;

  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        aligned;
  logic [1:0]  sync_state;
  logic [1:0]  offset;
  logic [15:0] code_err_cnt;
  logic [15:0] sync_loss_cnt;

  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_datak;
  logic        s_aligned;
  logic [1:0]  s_sync_state;
  logic [1:0]  s_offset;
  logic [3:0]  s_code_err_cnt;
  logic [3:0]  s_sync_loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_rx_word_sync #(.BYTES(4), .ACQUIRE_CNT(3), .LOSS_ERR_CNT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_datak(in_datak), .in_errdetect(in_errdetect), .in_disperr(in_disperr),
    .cnt_clear(cnt_clear), .out_valid(out_valid), .out_data(out_data),
    .out_datak(out_datak), .aligned(aligned), .sync_state(sync_state),
    .offset(offset), .code_err_cnt(code_err_cnt), .sync_loss_cnt(sync_loss_cnt)
  );

  fc_rx_word_sync #(.BYTES(4), .ACQUIRE_CNT(3), .LOSS_ERR_CNT(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_datak(in_datak), .in_errdetect(in_errdetect), .in_disperr(in_disperr),
    .cnt_clear(cnt_clear), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_datak(s_out_datak), .aligned(s_aligned), .sync_state(s_sync_state),
    .offset(s_offset), .code_err_cnt(s_code_err_cnt), .sync_loss_cnt(s_sync_loss_cnt)
  );

  // Present one word for one clock; outputs are sampled 1 time unit after the edge
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                      input logic [3:0] dp, input logic v);
    @(negedge clk);
    in_data      = d;
    in_datak     = k;
    in_errdetect = e;
    in_disperr   = dp;
    in_valid     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    cnt_clear = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (sync_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", sync_state); end
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got %0b want 0", aligned); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (offset !== 2'd0) begin errors++; $display("FAIL reset_offset got %0d want 0", offset); end
    checks++; if (code_err_cnt !== 16'd0 || sync_loss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", code_err_cnt, sync_loss_cnt);
    end
  endtask

  task automatic test_lane0();
    do_reset();
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    checks++; if (sync_state !== 2'd1) begin errors++; $display("FAIL lane0_acq1 got %0d want 1", sync_state); end
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL lane0_notyet got %0b want 0", aligned); end
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b1 || sync_state !== 2'd2) begin
      errors++; $display("FAIL lane0_sync got aligned=%0b state=%0d want 1/2", aligned, sync_state);
    end
    checks++; if (offset !== 2'd0) begin errors++; $display("FAIL lane0_offset got %0d want 0", offset); end
    checks++; if (out_valid !== 1'b1 || out_data !== BE_IDLE || out_datak !== 4'b1000) begin
      errors++; $display("FAIL lane0_out got v=%0b %h k=%b want 1 %h 1000", out_valid, out_data, out_datak, BE_IDLE);
    end
    // A distinct word appears one clock after the following valid word
    send(32'h44332211, 4'b0000, 4'h0, 4'h0, 1'b1);
    checks++; if (out_data !== BE_IDLE) begin errors++; $display("FAIL lane0_lat1 got %h want %h", out_data, BE_IDLE); end
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    checks++; if (out_data !== 32'h11223344 || out_datak !== 4'b0000) begin
      errors++; $display("FAIL lane0_lat2 got %h k=%b want 11223344 0000", out_data, out_datak);
    end
    // Idle gap: out_valid drops, everything else holds
    send(32'hDEADBEEF, 4'b1111, 4'hF, 4'h0, 1'b0);
    checks++; if (out_valid !== 1'b0 || aligned !== 1'b1 || out_data !== 32'h11223344) begin
      errors++; $display("FAIL gap_hold got v=%0b al=%0b %h want 0 1 11223344", out_valid, aligned, out_data);
    end
    checks++; if (code_err_cnt !== 16'd0) begin errors++; $display("FAIL gap_no_err got %0d want 0", code_err_cnt); end
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== BE_IDLE) begin
      errors++; $display("FAIL gap_resume got v=%0b %h want 1 %h", out_valid, out_data, BE_IDLE);
    end
  endtask

  task automatic test_lane2();
    do_reset();
    for (int i = 0; i < 3; i++) send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b1 || offset !== 2'd2) begin
      errors++; $display("FAIL lane2_sync got al=%0b off=%0d want 1 2", aligned, offset);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== BE_IDLE || out_datak !== 4'b1000) begin
        errors++; $display("FAIL lane2_out[%0d] got v=%0b %h k=%b want 1 %h 1000", i, out_valid, out_data, out_datak, BE_IDLE);
      end
      send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_relatch();
    do_reset();
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    send(IDLE0, IDLE0_K, 4'h0, 4'h0, 1'b1);
    send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    checks++; if (sync_state !== 2'd1 || offset !== 2'd2) begin
      errors++; $display("FAIL relatch_off got state=%0d off=%0d want 1 2", sync_state, offset);
    end
    send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    checks++; if (sync_state !== 2'd1) begin errors++; $display("FAIL relatch_acq got %0d want 1", sync_state); end
    send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    checks++; if (sync_state !== 2'd2 || aligned !== 1'b1) begin
      errors++; $display("FAIL relatch_sync got state=%0d al=%0b want 2 1", sync_state, aligned);
    end
  endtask

  task automatic test_loss();
    clear_counters();
    for (int i = 0; i < 3; i++) send(ROT2, ROT2_K, 4'b0001, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL loss_early got %0b want 1", aligned); end
    send(ROT2, ROT2_K, 4'b0001, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b0 || sync_state !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL loss_state got al=%0b st=%0d v=%0b want 0 0 0", aligned, sync_state, out_valid);
    end
    checks++; if (sync_loss_cnt !== 16'd1 || code_err_cnt !== 16'd4) begin
      errors++; $display("FAIL loss_counts got loss=%0d err=%0d want 1 4", sync_loss_cnt, code_err_cnt);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    for (int i = 0; i < 3; i++) send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(ROT2, ROT2_K, 4'b0001, 4'h0, 1'b1);
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL hyst_hold[%0d] got %0b want 1", i, aligned); end
      send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
      send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    end
    checks++; if (code_err_cnt !== 16'd10 || sync_state !== 2'd2) begin
      errors++; $display("FAIL hyst_end got err=%0d st=%0d want 10 2", code_err_cnt, sync_state);
    end
    // Invalid word with a stray K28.5 costs one credit, not two
    for (int i = 0; i < 3; i++) send(STRAY, STRAY_K, 4'b0001, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL both_once got %0b want 1", aligned); end
    send(STRAY, STRAY_K, 4'h0, 4'h0, 1'b1);
    checks++; if (aligned !== 1'b0 || sync_loss_cnt !== 16'd1 || code_err_cnt !== 16'd13) begin
      errors++; $display("FAIL stray_loss got al=%0b loss=%0d err=%0d want 0 1 13", aligned, sync_loss_cnt, code_err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) send(ROT2, ROT2_K, 4'h0, 4'b0010, 1'b1);
    checks++; if (s_code_err_cnt !== 4'd15) begin errors++; $display("FAIL sat_value got %0d want 15", s_code_err_cnt); end
    checks++; if (code_err_cnt !== 16'd20) begin errors++; $display("FAIL wide_value got %0d want 20", code_err_cnt); end
    send(ROT2, ROT2_K, 4'b1000, 4'h0, 1'b1);
    checks++; if (s_code_err_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", s_code_err_cnt); end
    cnt_clear = 1'b1;
    send(ROT2, ROT2_K, 4'b1000, 4'h0, 1'b1);
    cnt_clear = 1'b0;
    checks++; if (s_code_err_cnt !== 4'd0 || code_err_cnt !== 16'd0) begin
      errors++; $display("FAIL clear_prio got %0d/%0d want 0/0", s_code_err_cnt, code_err_cnt);
    end
    for (int i = 0; i < 3; i++) send(ROT2, ROT2_K, 4'h0, 4'h0, 1'b1);
    checks++; if (sync_state !== 2'd2) begin errors++; $display("FAIL pre_reset_sync got %0d want 2", sync_state); end
    do_reset();
    checks++; if (sync_state !== 2'd0 || aligned !== 1'b0 || out_valid !== 1'b0 || offset !== 2'd0) begin
      errors++; $display("FAIL midreset got st=%0d al=%0b v=%0b off=%0d want 0 0 0 0", sync_state, aligned, out_valid, offset);
    end
  endtask

  initial begin
    test_reset();
    test_lane0();
    test_lane2();
    test_relatch();
    test_loss();
    test_hysteresis();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
